au_arbiter: RTL and testbench

- Shares one arithmetic unit (`au`, sign-magnitude Q-format ADD/SUB/MUL/DIV) among NREQ requesters.
- Round-robin arbitration; one operation in flight at a time.
- Issues a single-cycle start to the AU, waits for its done pulse, then routes the result back to the owning requester.
- Rejects divide-by-zero without touching the AU, and has a watchdog that recovers from a lost done.

---
 rtl/au_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_au_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/au_arbiter.sv
// au_arbiter
//   Shares one sign-magnitude arithmetic unit among NREQ requesters with
//   round-robin arbitration and a single operation in flight. A winner's
//   operands are latched, a one-cycle start is sent to the AU, and the
//   result returned on done is routed back to the owner. Divide-by-zero is
//   answered locally with an error. A watchdog recovers from a lost done,
//   then drains the late result so it cannot be mistaken for a new one.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   req/req_op/req_muly          per-requester request, op_sel, mul_y_sel
//   req_r/req_s/req_imm          per-requester operands, W bits per slice
//   gnt                          one-cycle onehot grant
//   rsp_valid/rsp_data/rsp_err   one-cycle onehot response, data, error
//   au_start/au_r/au_s/au_imm    start pulse and operands to the AU
//   au_op/au_muly                op_sel and mul_y_sel to the AU
//   au_result/au_done/au_busy    AU result, done pulse, busy
module au_arbiter #(
  parameter int W    = 24,
  parameter int NREQ = 4,
  parameter int TMO  = 63
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    req_op,
  input  logic [2*NREQ-1:0]    req_muly,
  input  logic [W*NREQ-1:0]    req_r,
  input  logic [W*NREQ-1:0]    req_s,
  input  logic [W*NREQ-1:0]    req_imm,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [W-1:0]         rsp_data,
  output logic                 rsp_err,
  output logic                 au_start,
  output logic [W-1:0]         au_r,
  output logic [W-1:0]         au_s,
  output logic [W-1:0]         au_imm,
  output logic [1:0]           au_op,
  output logic [1:0]           au_muly,
  input  logic [W-1:0]         au_result,
  input  logic                 au_done,
  input  logic                 au_busy
);

  localparam int PW  = $clog2(NREQ);
  localparam int WDW = $clog2(TMO + 2) + 1;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_DRAIN
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [1:0]      r_cnt;
  logic [WDW-1:0]  r_wd;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_owner;
  logic            r_drain;
  logic            r_zflag;

  logic [1:0]      w_op_a   [NREQ];
  logic [1:0]      w_muly_a [NREQ];
  logic [W-1:0]    w_r_a    [NREQ];
  logic [W-1:0]    w_s_a    [NREQ];
  logic [W-1:0]    w_imm_a  [NREQ];

  logic            w_found;
  logic [PW-1:0]   w_win;
  logic            w_accept;
  logic            w_divz;
  logic            w_tmo;
  logic            w_drain_end;

  function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign w_op_a[gi]   = req_op[2*gi +: 2];
    assign w_muly_a[gi] = req_muly[2*gi +: 2];
    assign w_r_a[gi]    = req_r[W*gi +: W];
    assign w_s_a[gi]    = req_s[W*gi +: W];
    assign w_imm_a[gi]  = req_imm[W*gi +: W];
  end

  // Round-robin scan starting at the pointer, wrapping modulo NREQ.
  always_comb begin
    int j;
    j       = 0;
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(r_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!w_found && req[PW'(j)]) begin
        w_found = 1'b1;
        w_win   = PW'(j);
      end
    end
  end

  assign w_accept = (r_state == S_IDLE) && w_found && !au_busy;
  // Sign bit is ignored so that negative zero is also rejected.
  assign w_divz   = (w_op_a[w_win] == 2'b11) && (w_s_a[w_win][W-2:0] == '0);
  // The earliest possible done arrives in the second WAIT cycle; give up
  // TMO cycles after that slot.
  assign w_tmo       = (r_wd == WDW'(TMO + 1));
  assign w_drain_end = au_done || (r_wd == WDW'(TMO - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_INIT;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_INIT:  if (r_cnt == 2'd2 && !au_busy) w_state_nxt = S_IDLE;
      S_IDLE:  if (w_accept) w_state_nxt = w_divz ? S_RESP : S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (au_done || w_tmo) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = r_drain ? S_DRAIN : S_IDLE;
      S_DRAIN: if (w_drain_end) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_wd      <= '0;
      r_ptr     <= '0;
      r_owner   <= '0;
      r_drain   <= 1'b0;
      r_zflag   <= 1'b0;
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      au_start  <= 1'b0;
      au_r      <= '0;
      au_s      <= '0;
      au_imm    <= '0;
      au_op     <= '0;
      au_muly   <= '0;
    end else begin
      gnt       <= '0;
      rsp_valid <= '0;
      au_start  <= 1'b0;
      case (r_state)
        S_INIT: begin
          if (r_cnt != 2'd2) r_cnt <= r_cnt + 1'b1;
        end
        S_IDLE: begin
          if (w_accept) begin
            au_r    <= w_r_a[w_win];
            au_s    <= w_s_a[w_win];
            au_imm  <= w_imm_a[w_win];
            au_op   <= w_op_a[w_win];
            au_muly <= w_muly_a[w_win];
            r_owner <= w_win;
            r_ptr   <= (w_win == PW'(NREQ - 1)) ? '0 : w_win + 1'b1;
            gnt     <= onehot(w_win);
            au_start <= !w_divz;
            r_zflag <= w_divz;
            r_wd    <= '0;
          end
        end
        S_WAIT: begin
          if (au_done) begin
            rsp_data  <= au_result;
            rsp_err   <= 1'b0;
            rsp_valid <= onehot(r_owner);
          end else if (w_tmo) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= onehot(r_owner);
            r_drain   <= 1'b1;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        S_RESP: begin
          r_wd <= '0;
          // Divide-by-zero answers here, the cycle after its grant.
          if (r_zflag) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= onehot(r_owner);
            r_zflag   <= 1'b0;
          end
        end
        S_DRAIN: begin
          r_drain <= 1'b0;
          r_wd    <= r_wd + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_au_arbiter.sv
module tb_au_arbiter;

  localparam int W    = 24;
  localparam int NREQ = 4;
  localparam int TMO  = 63;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] req_op;
  logic [2*NREQ-1:0] req_muly;
  logic [W*NREQ-1:0] req_r;
  logic [W*NREQ-1:0] req_s;
  logic [W*NREQ-1:0] req_imm;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   rsp_valid;
  logic [W-1:0]      rsp_data;
  logic              rsp_err;
  logic              au_start;
  logic [W-1:0]      au_r;
  logic [W-1:0]      au_s;
  logic [W-1:0]      au_imm;
  logic [1:0]        au_op;
  logic [1:0]        au_muly;
  logic [W-1:0]      au_result = '0;
  logic              au_done   = 1'b0;
  logic              au_busy   = 1'b0;

  au_arbiter #(.W(W), .NREQ(NREQ), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_muly(req_muly),
    .req_r(req_r), .req_s(req_s), .req_imm(req_imm), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .au_start(au_start), .au_r(au_r), .au_s(au_s), .au_imm(au_imm),
    .au_op(au_op), .au_muly(au_muly), .au_result(au_result),
    .au_done(au_done), .au_busy(au_busy)
  );

  logic [109:0] all_outs;
  assign all_outs = {gnt, rsp_valid, rsp_err, rsp_data, au_start,
                     au_r, au_s, au_imm, au_op, au_muly};

  typedef struct { int idx; logic [W-1:0] data; logic err; int lat; } rsp_t;
  typedef struct { int idx; int exp_cyc; } gnt_t;
  typedef struct { logic [1:0] op; logic [1:0] muly; logic [W-1:0] r; logic [W-1:0] s; logic [W-1:0] imm; } iss_t;

  rsp_t sbq[$];
  gnt_t gntq[$];
  iss_t issq[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int gnt_cyc [NREQ];
  int last_gnt_cyc = 0;
  int busy_fall_cyc = 0;
  int inflight = 0;
  logic prev_busy = 1'b0;
  int model_lat = 2;
  int m_cnt = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d cycles required=finish", cyc);
    $fatal(1, "bench timeout");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Sign-magnitude Q14 reference arithmetic used by the AU stand-in.
  function automatic longint sm2i(input logic [W-1:0] x);
    longint m;
    m = longint'(x[W-2:0]);
    return x[W-1] ? -m : m;
  endfunction

  function automatic logic [W-1:0] i2sm(input longint v);
    if (v < 0) return {1'b1, 23'(-v)};
    return {1'b0, 23'(v)};
  endfunction

  function automatic logic [W-1:0] au_calc(input logic [1:0] op, input logic [W-1:0] r, input logic [W-1:0] s);
    longint a, b, v;
    a = sm2i(r);
    b = sm2i(s);
    case (op)
      2'b00:   v = a + b;
      2'b01:   v = a - b;
      2'b10:   v = (a * b) >>> 14;
      default: v = (b == 0) ? 0 : (a * 16384) / b;
    endcase
    return i2sm(v);
  endfunction

  // AU stand-in: no reset, done model_lat cycles after start, busy for DIV.
  always @(posedge clk) begin
    if (au_start) begin
      m_cnt     <= model_lat - 1;
      au_busy   <= (au_op == 2'b11);
      au_result <= au_calc(au_op, au_r, au_s);
      au_done   <= 1'b0;
    end else if (m_cnt == 1) begin
      au_done <= 1'b1;
      au_busy <= 1'b0;
      m_cnt   <= 0;
    end else begin
      au_done <= 1'b0;
      if (m_cnt > 1) m_cnt <= m_cnt - 1;
    end
  end

  // Monitor: pops expectations whenever the DUT presents gnt, au_start or rsp_valid.
  initial forever begin
    @(negedge clk);
    if (prev_busy && !au_busy) busy_fall_cyc = cyc;
    prev_busy = au_busy;
    if (rst) begin
      inflight = 0;
    end else begin
      if (gnt != '0) begin
        int gi;
        gnt_t g;
        gi = 0;
        for (int k = 0; k < NREQ; k++) if (gnt[k]) gi = k;
        check("gnt_onehot", $countones(gnt), 1);
        gnt_cyc[gi]  = cyc;
        last_gnt_cyc = cyc;
        if (gntq.size() == 0) begin
          check("gnt_unexpected", gnt, 0);
        end else begin
          g = gntq.pop_front();
          check("gnt_idx", gi, g.idx);
          if (g.exp_cyc >= 0) check("gnt_cycle", cyc, g.exp_cyc);
        end
      end
      if (au_start) begin
        iss_t e;
        check("start_single_inflight", inflight, 0);
        check("start_with_gnt", (gnt != '0), 1);
        inflight = 1;
        if (issq.size() == 0) begin
          check("start_unexpected", au_start, 0);
        end else begin
          e = issq.pop_front();
          check("au_fields", {au_op, au_muly, au_r, au_s, au_imm},
                {e.op, e.muly, e.r, e.s, e.imm});
        end
      end
      if (rsp_valid != '0) begin
        int ri;
        rsp_t e;
        ri = 0;
        for (int k = 0; k < NREQ; k++) if (rsp_valid[k]) ri = k;
        inflight = 0;
        check("rsp_onehot", $countones(rsp_valid), 1);
        if (sbq.size() == 0) begin
          check("rsp_unexpected", rsp_valid, 0);
        end else begin
          e = sbq.pop_front();
          check("rsp_idx", ri, e.idx);
          check("rsp_data", rsp_data, e.data);
          check("rsp_err", rsp_err, e.err);
          if (e.lat >= 0) check("rsp_latency", cyc - gnt_cyc[ri], e.lat);
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [1:0] op, input logic [W-1:0] r, input logic [W-1:0] s);
    req_op[2*i +: 2]   = op;
    req_muly[2*i +: 2] = 2'b00;
    req_r[W*i +: W]    = r;
    req_s[W*i +: W]    = s;
    req_imm[W*i +: W]  = 24'h000100 + 24'(i);
  endtask

  task automatic push_iss(input int i);
    iss_t e;
    e.op   = req_op[2*i +: 2];
    e.muly = req_muly[2*i +: 2];
    e.r    = req_r[W*i +: W];
    e.s    = req_s[W*i +: W];
    e.imm  = req_imm[W*i +: W];
    issq.push_back(e);
  endtask

  task automatic push_gnt(input int i, input int exp_cyc);
    gnt_t g;
    g.idx = i;
    g.exp_cyc = exp_cyc;
    gntq.push_back(g);
  endtask

  task automatic push_rsp(input int i, input logic [W-1:0] d, input logic e, input int lat);
    rsp_t r;
    r.idx = i; r.data = d; r.err = e; r.lat = lat;
    sbq.push_back(r);
  endtask

  // One cycle: a requester drops req once it sees its grant.
  task automatic step();
    @(negedge clk);
    req = req & ~gnt;
  endtask

  task automatic serve(input int budget);
    int n;
    n = 0;
    while ((req != '0 || sbq.size() != 0 || gntq.size() != 0 || issq.size() != 0) && n < budget) begin
      step();
      n++;
    end
    check("serve_bound", (n < budget), 1);
  endtask

  initial begin
    int c;
    int n;
    rst = 1'b1;
    req = '0;
    req_op = '0; req_muly = '0; req_r = '0; req_s = '0; req_imm = '0;

    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs, 0);
    rst = 1'b0;
    @(negedge clk);
    check("init_outputs", all_outs, 0);
    repeat (5) @(negedge clk);

    // Four simultaneous SUBs: 1.0 - (-1.0) = 2.0, granted 0,1,2,3.
    c = cyc;
    for (int i = 0; i < NREQ; i++) begin
      set_req(i, 2'b01, 24'h004000, 24'h804000);
      push_iss(i);
      push_gnt(i, c + 1 + 5 * i);
      push_rsp(i, 24'h008000, 1'b0, 3);
    end
    req = '1;
    serve(200);

    // Single ADD: 1.0 + 0.5 = 1.5.
    repeat (2) @(negedge clk);
    set_req(0, 2'b00, 24'h004000, 24'h002000);
    push_iss(0);
    push_gnt(0, cyc + 1);
    push_rsp(0, 24'h006000, 1'b0, 3);
    req[0] = 1'b1;
    serve(50);
    repeat (3) @(negedge clk);
    check("rsp_data_hold", rsp_data, 24'h006000);
    check("rsp_valid_idle", rsp_valid, 0);

    // MUL: 1.5 * -0.5 = -0.75.
    set_req(3, 2'b10, 24'h006000, 24'h802000);
    push_iss(3);
    push_gnt(3, cyc + 1);
    push_rsp(3, 24'h803000, 1'b0, 3);
    req[3] = 1'b1;
    serve(50);

    // DIV by negative zero: rejected locally, no au_start.
    repeat (2) @(negedge clk);
    set_req(2, 2'b11, 24'h004000, 24'h800000);
    push_gnt(2, cyc + 1);
    push_rsp(2, 24'h000000, 1'b1, 1);
    req[2] = 1'b1;
    serve(50);

    // DIV 1.0 / 2.0 = 0.5 with a slow, busy AU.
    repeat (2) @(negedge clk);
    model_lat = 6;
    set_req(1, 2'b11, 24'h004000, 24'h008000);
    push_iss(1);
    push_gnt(1, cyc + 1);
    push_rsp(1, 24'h002000, 1'b0, 7);
    req[1] = 1'b1;
    serve(50);
    model_lat = 2;

    // Lost done: watchdog error, late done swallowed in DRAIN, next op clean.
    repeat (2) @(negedge clk);
    model_lat = TMO + 10;
    set_req(3, 2'b00, 24'h001000, 24'h001000);
    push_iss(3);
    push_gnt(3, cyc + 1);
    push_rsp(3, 24'h000000, 1'b1, TMO + 3);
    req[3] = 1'b1;
    serve(TMO + 40);
    model_lat = 2;
    c = last_gnt_cyc;
    set_req(0, 2'b00, 24'h000100, 24'h000200);
    push_iss(0);
    push_gnt(0, c + TMO + 12);
    push_rsp(0, 24'h000300, 1'b0, 3);
    req[0] = 1'b1;
    serve(TMO + 40);

    // Reset in WAIT while the AU is busy: pending response is lost.
    repeat (2) @(negedge clk);
    model_lat = 20;
    set_req(2, 2'b11, 24'h004000, 24'h004000);
    push_iss(2);
    push_gnt(2, cyc + 1);
    req[2] = 1'b1;
    n = 0;
    while (issq.size() != 0 && n < 20) begin
      step();
      n++;
    end
    check("start_seen_bound", (n < 20), 1);
    repeat (2) step();
    model_lat = 2;
    set_req(1, 2'b00, 24'h000005, 24'h000003);
    req[1] = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    check("rst_async_outputs", all_outs, 0);
    push_iss(1);
    push_gnt(1, -1);
    push_rsp(1, 24'h000008, 1'b0, 3);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    serve(100);
    check("gnt_after_busy", last_gnt_cyc, busy_fall_cyc + 2);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
